// File: rtl/md_sched_if.sv
// Pipeline-side bundle for the multiply/divide scheduler: E-stage operands and op code in,
// HI/LO state, busy/stall status and the mfhi/mflo read value out.
interface md_sched_if;
   logic [3:0]  E_MDOp;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        D_MDUse;
   logic        Busy;
   logic        Start;
   logic        MD_Stall;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] E_MDRD;

   modport master (
      output E_MDOp, E_A, E_B, D_MDUse,
      input  Busy, Start, MD_Stall, HI, LO, E_MDRD
   );

   modport slave (
      input  E_MDOp, E_A, E_B, D_MDUse,
      output Busy, Start, MD_Stall, HI, LO, E_MDRD
   );
endinterface

// File: rtl/md_sched.sv
// E-stage multiply/divide scheduler: computes the result at Start, keeps HI/LO busy for a
// fixed latency, then commits. Also serves mfhi/mflo/mthi/mtlo and the D-stage stall request.
module md_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset,
   md_sched_if.slave md
);
   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMfhi  = 4'd5;
   localparam logic [3:0] OpMflo  = 4'd6;
   localparam logic [3:0] OpMthi  = 4'd7;
   localparam logic [3:0] OpMtlo  = 4'd8;

   typedef enum logic {StIdle, StRun} state_e;

   state_e          r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]     r_hi, w_hi_nxt;
   logic [31:0]     r_lo, w_lo_nxt;
   logic [31:0]     r_pend_hi, w_pend_hi_nxt;
   logic [31:0]     r_pend_lo, w_pend_lo_nxt;
   logic            r_pend_vld, w_pend_vld_nxt;

   logic w_is_arith, w_is_div, w_busy, w_start;

   logic               w_a_neg, w_b_neg;
   logic [31:0]        w_a_mag, w_b_mag, w_dvsr, w_q_mag, w_r_mag, w_quot, w_rem;
   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod_u;
   logic [31:0]        w_res_hi, w_res_lo;
   logic               w_res_vld;

   assign w_is_arith = (md.E_MDOp >= OpMult) && (md.E_MDOp <= OpDivu);
   assign w_is_div   = (md.E_MDOp == OpDiv) || (md.E_MDOp == OpDivu);
   assign w_busy     = (r_state == StRun);
   assign w_start    = w_is_arith && !w_busy;

   assign w_prod_s = 64'($signed(md.E_A)) * 64'($signed(md.E_B));
   assign w_prod_u = 64'(md.E_A) * 64'(md.E_B);

   // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
   assign w_a_neg = (md.E_MDOp == OpDiv) && md.E_A[31];
   assign w_b_neg = (md.E_MDOp == OpDiv) && md.E_B[31];
   assign w_a_mag = w_a_neg ? (32'd0 - md.E_A) : md.E_A;
   assign w_b_mag = w_b_neg ? (32'd0 - md.E_B) : md.E_B;
   assign w_dvsr  = (md.E_B == 32'd0) ? 32'd1 : w_b_mag;
   assign w_q_mag = w_a_mag / w_dvsr;
   assign w_r_mag = w_a_mag % w_dvsr;
   assign w_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

   always_comb begin
      w_res_hi  = 32'd0;
      w_res_lo  = 32'd0;
      w_res_vld = 1'b0;
      case (md.E_MDOp)
         OpMult: begin
            {w_res_hi, w_res_lo} = w_prod_s;
            w_res_vld            = 1'b1;
         end
         OpMultu: begin
            {w_res_hi, w_res_lo} = w_prod_u;
            w_res_vld            = 1'b1;
         end
         OpDiv, OpDivu: begin
            w_res_hi  = w_rem;
            w_res_lo  = w_quot;
            w_res_vld = (md.E_B != 32'd0);
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_hi_nxt       = r_hi;
      w_lo_nxt       = r_lo;
      w_pend_hi_nxt  = r_pend_hi;
      w_pend_lo_nxt  = r_pend_lo;
      w_pend_vld_nxt = r_pend_vld;

      // Moves apply first so a same-edge commit overrides them.
      if (md.E_MDOp == OpMthi) w_hi_nxt = md.E_A;
      if (md.E_MDOp == OpMtlo) w_lo_nxt = md.E_A;

      case (r_state)
         StIdle: begin
            if (w_start) begin
               w_state_nxt    = StRun;
               w_cnt_nxt      = w_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
               w_pend_hi_nxt  = w_res_hi;
               w_pend_lo_nxt  = w_res_lo;
               w_pend_vld_nxt = w_res_vld;
            end
         end
         StRun: begin
            w_cnt_nxt = r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) begin
               w_state_nxt = StIdle;
               if (r_pend_vld) begin
                  w_hi_nxt = r_pend_hi;
                  w_lo_nxt = r_pend_lo;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_pend_hi  <= 32'd0;
         r_pend_lo  <= 32'd0;
         r_pend_vld <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hi       <= w_hi_nxt;
         r_lo       <= w_lo_nxt;
         r_pend_hi  <= w_pend_hi_nxt;
         r_pend_lo  <= w_pend_lo_nxt;
         r_pend_vld <= w_pend_vld_nxt;
      end
   end

   assign md.Busy     = w_busy;
   assign md.Start    = w_start;
   assign md.MD_Stall = md.D_MDUse & (w_start | w_busy);
   assign md.HI       = r_hi;
   assign md.LO       = r_lo;
   assign md.E_MDRD   = (md.E_MDOp == OpMfhi) ? r_hi :
                        (md.E_MDOp == OpMflo) ? r_lo : 32'd0;
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- E-stage multiply/divide scheduler for the five-stage MIPS pipeline.
- Accepts mult/multu/div/divu from E, holds the HI/LO resource busy for a fixed latency, then commits results.
- Serves mfhi/mflo/mthi/mtlo.
- Raises a stall request so the hazard unit freezes D while an md-class instruction in D would collide with an in-flight operation.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset (reset==0 at a clk edge clears state)
- E_MDOp  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others = none
- E_A  input  32  forwarded rs value (E_real_rs)
- E_B  input  32  forwarded rt value (E_real_rt)
- D_MDUse  input  1  D-stage instruction is any md-class op (codes 1-8)
- Busy  output  1  operation in flight
- Start  output  1  combinational: E_MDOp in {1..4} and !Busy
- MD_Stall  output  1  combinational: D_MDUse & (Start | Busy)
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- E_MDRD  output  32  mfhi ? HI : mflo ? LO : 0, combinational

Behaviour:
- Reset (reset==0 at posedge): HI=0, LO=0, Busy=0, counter=0, pending HI/LO=0, pending-valid=0. This aborts any in-flight operation; no commit occurs.
- States: IDLE (Busy=0) and RUN (Busy=1). An internal down-counter of width clog2(max(MULT,DIV)+1) tracks progress.
- IDLE -> RUN on a Start edge:
  - Compute the result from E_A/E_B at the Start edge and store it in pending regs.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from the next cycle.
- In RUN, the counter decrements each edge. When counter==1 at an edge:
  - HI/LO <= pending (if pending-valid).
  - Busy <= 0 and return to IDLE.
- Timing: Busy is high for exactly N consecutive cycles. New HI/LO values are visible in the cycle Busy falls.
- mult: signed 64-bit product, {HI,LO}. multu: unsigned product.
- div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (E_B==0):
  - The operation is still scheduled and Busy runs DIV_CYCLES.
  - pending-valid=0, so HI/LO keep their old values.
- mthi/mtlo:
  - Legal only when !Busy; write E_A to HI/LO at the edge.
  - If asserted while Busy (hazard-unit error), the write happens but is overwritten by the commit.
  - If asserted while Start is low and Busy is low, the write applies immediately.
- mfhi/mflo: read the architectural HI/LO; E_MDRD is not forwarded from pending.
- Start while Busy (E_MDOp 1-4 with Busy=1): ignored; the counter and pending regs are unchanged. The hazard unit prevents this via MD_Stall.
- Pipeline contract: MD_Stall is ORed into the top-level Stall.
  - A stalled D inserts a bubble into E (E_MDOp=0).
  - The D md-instruction stays in D until the cycle Busy falls and no Start is pending.
- Commit and mthi/mtlo at the same edge cannot occur legally. If forced, the commit wins.

Test Plan:
- mult with E_A=0xFFFFFFFD (-3), E_B=5 for one cycle -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div with E_A=0xFFFFFFF9 (-7), E_B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with 7, 2 -> LO=3, HI=1.
- mthi 0x12345678, then divu x/0 -> Busy runs 10 cycles; HI stays 0x12345678, and mfhi gives E_MDRD=0x12345678.
- mult issued with D_MDUse=1 on the following cycles -> MD_Stall=1 on the Start cycle and for all 5 busy cycles, 0 once Busy falls. Issuing the op again while Busy changes nothing.
- Start a div, drive reset=0 at busy cycle 4 -> next cycle Busy=0, HI=LO=0, and no later commit appears.
- 0x80000000 div 0xFFFFFFFF -> LO=0x80000000, HI=0. Back-to-back multu 0xFFFFFFFF*0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.
